// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder: command opcodes,
// mode-register value and the transaction state encoding.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] MODE_SEQ  = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RDMR_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives single-cycle
// SPI clock edge strobes; every output lags its pin by SYNC_STAGES clk.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_select,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sel_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] sel_q, sel_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic                   sclk_prev_q, sclk_prev_d;

  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], spi_clk};
    sel_d       = {sel_q[SYNC_STAGES-2:0], spi_select};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
  end

  // Select resets to its deasserted (high) level so reset never looks like a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      sel_q       <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      sel_q       <= sel_d;
      mosi_q      <= mosi_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign sclk_rise  = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
  assign sel_active = ~sel_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM emulation (READ/WRITE/RDMR, 16-bit sequential address)
// backed by an internal byte array, fully oversampled by the system clock.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_select,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic active,
  output logic wr_pulse,
  output logic cmd_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic sclk_rise, sclk_fall, sel_active, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_select (spi_select),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .sel_active (sel_active),
    .mosi_s     (mosi_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        is_wr_q, is_wr_d;
  logic        cmd_err_q, cmd_err_d;
  logic        wr_pulse_q, wr_pulse_d;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic [15:0] nxt_addr;
  logic [7:0]  rd_data;
  logic        mem_we;

  assign rx_byte   = {shift_q, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  // One adder serves the first read address, every auto-increment and its prefetch.
  assign nxt_addr  = (state_q == ST_ADDR_LO) ? {addr_q[15:8], rx_byte} : addr_q + 16'd1;
  assign rd_data   = mem[nxt_addr[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    is_wr_d    = is_wr_q;
    cmd_err_d  = cmd_err_q;
    wr_pulse_d = 1'b0;
    mem_we     = 1'b0;

    if (sclk_rise && state_q != ST_IDLE) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = rx_byte[6:0];
    end
    if (sclk_fall && (state_q == ST_RD_DATA || state_q == ST_RDMR_DATA)) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_active) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          case (rx_byte)
            CMD_READ:  begin is_wr_d = 1'b0; state_d = ST_ADDR_HI; end
            CMD_WRITE: begin is_wr_d = 1'b1; state_d = ST_ADDR_HI; end
            CMD_RDMR:  begin tx_d = MODE_SEQ; state_d = ST_RDMR_DATA; end
            default:   begin cmd_err_d = 1'b1; state_d = ST_IGNORE; end
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (byte_done) begin
          addr_d  = {rx_byte, addr_q[7:0]};
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (byte_done) begin
          addr_d  = nxt_addr;
          tx_d    = rd_data;
          state_d = is_wr_q ? ST_WR_DATA : ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (byte_done) begin
          addr_d = nxt_addr;
          tx_d   = rd_data;
        end
      end
      ST_WR_DATA: begin
        if (byte_done) begin
          mem_we     = 1'b1;
          wr_pulse_d = 1'b1;
          addr_d     = nxt_addr;
        end
      end
      ST_RDMR_DATA: begin
        if (byte_done) tx_d = MODE_SEQ;
      end
      ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    // Deselect wins over the state, but an edge seen in the same cycle still commits above.
    if (!sel_active && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      addr_q     <= 16'd0;
      tx_q       <= 8'd0;
      miso_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      is_wr_q    <= is_wr_d;
      cmd_err_q  <= cmd_err_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[AW-1:0]] <= rx_byte;
  end

  assign spi_miso = miso_q;
  assign active   = (state_q != ST_IDLE);
  assign wr_pulse = wr_pulse_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Table-driven bench for spi_sram_responder: SPI transactions from a vector table,
// received MISO bytes checked against a scoreboard queue, plus hand-written corner cases.
module tb_spi_sram_responder;
  import spi_sram_pkg::*;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n, spi_select, spi_clk, spi_mosi;
  logic spi_miso, active, wr_pulse, cmd_err;

  always #5 clk = ~clk;

  spi_sram_responder #(.DEPTH(256), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_select (spi_select),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .active     (active),
    .wr_pulse   (wr_pulse),
    .cmd_err    (cmd_err)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          n;
    logic [15:0] data;
    int          exp_wr;
    logic        exp_err;
  } txn_t;

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         wr_cnt   = 0;
  logic [7:0] sb_q[$];
  txn_t       tbl [10];

  always @(posedge clk) if (wr_pulse) wr_cnt <= wr_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(HALF);
      rx[7-i] = spi_miso;
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input string name);
    logic [7:0] rx, e;
    sb_q.push_back(exp);
    spi_bits(tx, 8, rx);
    if (sb_q.size() == 0) begin
      check({name, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(name, {24'd0, rx}, {24'd0, e});
    end
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int         wr0;
    logic       rd;
    logic [7:0] d;
    wr0 = wr_cnt;
    rd  = (t.cmd == CMD_READ) || (t.cmd == CMD_RDMR);
    spi_select = 1'b0;
    wait_clk(HALF);
    check($sformatf("%s active_hi", tag), {31'd0, active}, 32'd1);
    xfer(t.cmd, 8'h00, $sformatf("%s cmd", tag));
    if (t.cmd != CMD_RDMR) begin
      xfer(t.addr[15:8], 8'h00, $sformatf("%s addr_hi", tag));
      xfer(t.addr[7:0],  8'h00, $sformatf("%s addr_lo", tag));
    end
    for (int i = 0; i < t.n; i++) begin
      d = (i == 0) ? t.data[15:8] : t.data[7:0];
      xfer(rd ? ~d : d, rd ? d : 8'h00, $sformatf("%s data%0d", tag, i));
    end
    wait_clk(HALF);
    spi_select = 1'b1;
    wait_clk(HALF);
    check($sformatf("%s active_lo", tag), {31'd0, active}, 32'd0);
    check($sformatf("%s miso_idle", tag), {31'd0, spi_miso}, 32'd0);
    check($sformatf("%s wr_pulses", tag), wr_cnt - wr0, t.exp_wr);
    check($sformatf("%s cmd_err", tag), {31'd0, cmd_err}, {31'd0, t.exp_err});
    $display("txn %s cmd=%02h addr=%04h bytes=%0d", tag, t.cmd, t.addr, t.n);
  endtask

  initial begin
    txn_t       t;
    logic [7:0] rx;
    int         wr0;

    tbl[0] = '{8'h02, 16'h0010, 2, 16'hA53C, 2, 1'b0};
    tbl[1] = '{8'h03, 16'h0010, 2, 16'hA53C, 0, 1'b0};
    tbl[2] = '{8'h02, 16'hFFFF, 2, 16'h1122, 2, 1'b0};
    tbl[3] = '{8'h03, 16'h0000, 1, 16'h2200, 0, 1'b0};
    tbl[4] = '{8'h03, 16'h00FF, 2, 16'h1122, 0, 1'b0};
    tbl[5] = '{8'h03, 16'hFFFF, 2, 16'h1122, 0, 1'b0};
    tbl[6] = '{8'h05, 16'h0000, 2, 16'h4040, 0, 1'b0};
    tbl[7] = '{8'h9F, 16'h1234, 1, 16'hFF00, 0, 1'b1};
    tbl[8] = '{8'h03, 16'h0010, 1, 16'hA500, 0, 1'b1};
    tbl[9] = '{8'h02, 16'h0020, 1, 16'h5A00, 1, 1'b1};

    rst_n = 1'b0; spi_select = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    wait_clk(4);
    check("rst miso", {31'd0, spi_miso}, 32'd0);
    check("rst active", {31'd0, active}, 32'd0);
    check("rst wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("rst cmd_err", {31'd0, cmd_err}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int k = 0; k < 10; k++) run_txn(tbl[k], $sformatf("tbl%0d", k));

    // Abort a write after 5 data bits; nothing may be committed.
    wr0 = wr_cnt;
    spi_select = 1'b0;
    wait_clk(HALF);
    xfer(CMD_WRITE, 8'h00, "abort cmd");
    xfer(8'h00, 8'h00, "abort addr_hi");
    xfer(8'h20, 8'h00, "abort addr_lo");
    spi_bits(8'hFF, 5, rx);
    wait_clk(HALF);
    spi_select = 1'b1;
    wait_clk(HALF);
    check("abort wr_pulses", wr_cnt - wr0, 0);
    check("abort active_lo", {31'd0, active}, 32'd0);
    $display("txn abort write addr=0020 bits=5");
    t = '{8'h03, 16'h0020, 1, 16'h5A00, 0, 1'b1};
    run_txn(t, "after_abort");

    // Deselect arrives on the same clock as the 8th data rise: byte still commits.
    wr0 = wr_cnt;
    spi_select = 1'b0;
    wait_clk(HALF);
    xfer(CMD_WRITE, 8'h00, "edge cmd");
    xfer(8'h00, 8'h00, "edge addr_hi");
    xfer(8'h30, 8'h00, "edge addr_lo");
    spi_bits(8'h77, 7, rx);
    spi_mosi = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b1;
    spi_select = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b0;
    wait_clk(HALF);
    check("edge wr_pulses", wr_cnt - wr0, 1);
    check("edge active_lo", {31'd0, active}, 32'd0);
    $display("txn edge write addr=0030 data=77 deselect-on-last-rise");
    t = '{8'h03, 16'h0030, 1, 16'h7700, 0, 1'b1};
    run_txn(t, "edge_readback");

    // Reset in the middle of a read, with spi_clk high after the 3rd data rise.
    spi_select = 1'b0;
    wait_clk(HALF);
    xfer(CMD_READ, 8'h00, "rstrd cmd");
    xfer(8'h00, 8'h00, "rstrd addr_hi");
    xfer(8'h10, 8'h00, "rstrd addr_lo");
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b0;
      wait_clk(HALF);
      spi_clk = 1'b1;
      wait_clk(HALF);
      if (i < 2) spi_clk = 1'b0;
    end
    check("rstrd miso_bit5", {31'd0, spi_miso}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstrd async miso", {31'd0, spi_miso}, 32'd0);
    check("rstrd async active", {31'd0, active}, 32'd0);
    spi_clk = 1'b0;
    spi_select = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    $display("txn reset during read addr=0010");
    t = '{8'h03, 16'h0010, 2, 16'hA53C, 0, 1'b0};
    run_txn(t, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
